// File: rtl/glbl_reg_bridge.sv
// glbl_reg_bridge: Wishbone B4 classic slave to reg-bus master bridge for the
// global config register block (mclk domain). One Wishbone cycle becomes one
// reg-bus access, with reg_cs held until reg_ack.
//
// Ports:
//   mclk, reset_n           clock, asynchronous active-low reset
//   wb_cyc_i .. wb_sel_i    Wishbone slave request (cycle, strobe, we, adr, data, sel)
//   wb_dat_o                read data (ERR_RDATA on error), held until next completion
//   wb_ack_o, wb_err_o      one-cycle completion pulses
//   reg_cs .. reg_be        reg-bus request; address/data/enables hold while reg_cs=0
//   reg_rdata, reg_ack      reg-bus response
//   timeout_sts             sticky timeout flag; timeout_clr clears it (set wins)
module glbl_reg_bridge #(
  parameter logic [31:0] BASE_ADDR   = 32'h3002_0000,
  parameter logic [7:0]  TIMEOUT_CYC = 8'd255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_DEAD
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        reg_cs,
  output logic        reg_wr,
  output logic [7:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack,
  output logic        timeout_sts,
  input  logic        timeout_clr
);

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

  state_e      r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_wb_dat;
  logic        r_wb_ack;
  logic        r_wb_err;
  logic        r_cs;
  logic        r_wr;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_tsts;

  logic w_in_win;
  logic w_timeout;

  assign w_in_win  = (wb_adr_i[31:8] == BASE_ADDR[31:8]);
  assign w_timeout = (r_cnt == (TIMEOUT_CYC - 8'd1));

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= StIdle;
      r_cnt    <= 8'd0;
      r_wb_dat <= 32'd0;
      r_wb_ack <= 1'b0;
      r_wb_err <= 1'b0;
      r_cs     <= 1'b0;
      r_wr     <= 1'b0;
      r_addr   <= 8'd0;
      r_wdata  <= 32'd0;
      r_be     <= 4'd0;
      r_tsts   <= 1'b0;
    end else begin
      // Clear first so a timeout later in this block overrides it.
      if (timeout_clr) begin
        r_tsts <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          if (wb_cyc_i && wb_stb_i) begin
            if (w_in_win) begin
              r_wr    <= wb_we_i;
              r_addr  <= wb_adr_i[7:0];
              r_wdata <= wb_dat_i;
              r_be    <= wb_sel_i;
              r_cs    <= 1'b1;
              r_cnt   <= 8'd0;
              r_state <= StReq;
            end else begin
              r_wb_err <= 1'b1;
              r_wb_dat <= ERR_RDATA;
              r_state  <= StResp;
            end
          end
        end

        StReq: begin
          r_cnt <= r_cnt + 8'd1;
          // Priority: target ack > timeout > master abort.
          if (reg_ack) begin
            r_cs     <= 1'b0;
            r_wb_dat <= r_wr ? 32'd0 : reg_rdata;
            r_wb_ack <= 1'b1;
            r_state  <= StResp;
          end else if (w_timeout) begin
            r_cs     <= 1'b0;
            r_wb_err <= 1'b1;
            r_wb_dat <= ERR_RDATA;
            r_tsts   <= 1'b1;
            r_state  <= StResp;
          end else if (!wb_cyc_i) begin
            r_cs    <= 1'b0;
            r_state <= StIdle;
          end
        end

        StResp: begin
          // Strobe is ignored here so a lingering stb is not re-accepted.
          r_wb_ack <= 1'b0;
          r_wb_err <= 1'b0;
          r_state  <= StIdle;
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign wb_dat_o    = r_wb_dat;
  assign wb_ack_o    = r_wb_ack;
  assign wb_err_o    = r_wb_err;
  assign reg_cs      = r_cs;
  assign reg_wr      = r_wr;
  assign reg_addr    = r_addr;
  assign reg_wdata   = r_wdata;
  assign reg_be      = r_be;
  assign timeout_sts = r_tsts;

endmodule
